// File: rtl/captura_7seg_pkg.sv
// captura_7seg_pkg
// Shared definitions for the 7-segment capture block.
// Contents:
//   COD_0..COD_9, COD_BLANCO : active-low segment codes, bit order a..g (MSB = a)
//   VALOR_BLANCO             : value reported for a blank digit
//   estado_t                 : capture FSM state encoding
//   es_uno_bajo()            : one-hot-low check used on the anode strobe
package captura_7seg_pkg;

  // Active-low segment patterns {a,b,c,d,e,f,g}; a zero means the segment is lit.
  localparam logic [6:0] COD_0      = 7'b0000001;
  localparam logic [6:0] COD_1      = 7'b1001111;
  localparam logic [6:0] COD_2      = 7'b0010010;
  localparam logic [6:0] COD_3      = 7'b0000110;
  localparam logic [6:0] COD_4      = 7'b1001100;
  localparam logic [6:0] COD_5      = 7'b0100100;
  localparam logic [6:0] COD_6      = 7'b0100000;
  localparam logic [6:0] COD_7      = 7'b0001111;
  localparam logic [6:0] COD_8      = 7'b0000000;
  localparam logic [6:0] COD_9      = 7'b0000100;
  localparam logic [6:0] COD_BLANCO = 7'b1111111;

  localparam logic [3:0] VALOR_BLANCO = 4'hF;

  typedef enum logic [1:0] {
    ESPERA        = 2'd0,
    ESTABILIZANDO = 2'd1,
    CAPTURADO     = 2'd2
  } estado_t;

  // True when exactly one bit of a 32-bit active-high vector is set.
  // Callers zero-extend their narrower strobe vectors.
  function automatic logic es_uno_bajo(input logic [31:0] activos);
    return (activos != 32'd0) && ((activos & (activos - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/decodificador_7seg_bcd.sv
// decodificador_7seg_bcd
// Combinational inverse of the BCD-to-7-segment table.
// Ports:
//   codigo_i [6:0] : active-low segment code {a,b,c,d,e,f,g}
//   legal_o        : code is one of the ten decimal digits
//   blanco_o       : code has every segment off
//   valor_o  [3:0] : decoded digit; VALOR_BLANCO when not a decimal digit
module decodificador_7seg_bcd
  import captura_7seg_pkg::*;
(
  input  logic [6:0] codigo_i,
  output logic       legal_o,
  output logic       blanco_o,
  output logic [3:0] valor_o
);

  // Table lookup; anything not listed falls through as illegal.
  always_comb begin
    legal_o  = 1'b1;
    blanco_o = 1'b0;
    valor_o  = VALOR_BLANCO;
    case (codigo_i)
      COD_0:      valor_o = 4'd0;
      COD_1:      valor_o = 4'd1;
      COD_2:      valor_o = 4'd2;
      COD_3:      valor_o = 4'd3;
      COD_4:      valor_o = 4'd4;
      COD_5:      valor_o = 4'd5;
      COD_6:      valor_o = 4'd6;
      COD_7:      valor_o = 4'd7;
      COD_8:      valor_o = 4'd8;
      COD_9:      valor_o = 4'd9;
      COD_BLANCO: begin
        legal_o  = 1'b0;
        blanco_o = 1'b1;
      end
      default:    legal_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/captura_7seg_bcd.sv
// captura_7seg_bcd
// Samples the multiplexed bus of an external 4-digit 7-segment driver and
// recovers the BCD value shown on each digit, flagging complete frames.
// Parameters:
//   NUM_DIG : number of anode lines / digits
//   ESTABLE : identical synchronized samples needed before a digit commits
// Ports:
//   clk, reset                   : clock, synchronous active-high reset
//   anodos_in    [NUM_DIG-1:0]   : active-low anode strobes
//   seg_in       [7:0]           : active-low segments {a,b,c,d,e,f,g,dp}
//   valores_out  [4*NUM_DIG-1:0] : digit i value at [4i+3:4i]
//   dig_valido   [NUM_DIG-1:0]   : digit i holds a legal decimal code
//   trama_valida                 : one-cycle pulse, all digits committed
//   error_codigo                 : one-cycle pulse, stable strobe with illegal code
//   dp_out       [NUM_DIG-1:0]   : decimal point per digit (CAPTURA_DP_EN only)
// Build option: define CAPTURA_DP_EN to capture the decimal point; otherwise
// seg_in[0] is ignored completely.
module captura_7seg_bcd
  import captura_7seg_pkg::*;
#(
  parameter int NUM_DIG = 4,
  parameter int ESTABLE = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_DIG-1:0]   anodos_in,
  input  logic [7:0]           seg_in,
  output logic [4*NUM_DIG-1:0] valores_out,
  output logic [NUM_DIG-1:0]   dig_valido,
  output logic                 trama_valida,
  output logic                 error_codigo
`ifdef CAPTURA_DP_EN
  ,
  output logic [NUM_DIG-1:0]   dp_out
`endif
);

  localparam int CNT_W = (ESTABLE < 1) ? 1 : $clog2(ESTABLE + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ESTABLE);
  localparam logic [CNT_W-1:0] CNT_UNO = CNT_W'(1);

`ifdef CAPTURA_DP_EN
  localparam int SEG_W = 8;
  logic [SEG_W-1:0] segEntrada;
  assign segEntrada = seg_in;
`else
  // Without the dp option the dp line never enters the design, so it cannot
  // disturb the stability compare.
  localparam int SEG_W = 7;
  logic [SEG_W-1:0] segEntrada;
  logic             segDp_unused;
  assign segEntrada   = seg_in[7:1];
  assign segDp_unused = seg_in[0];
`endif

  logic [NUM_DIG-1:0]   anMeta_q, anSync_q, anPrev_q;
  logic [SEG_W-1:0]     segMeta_q, segSync_q, segPrev_q;

  estado_t              state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 commit;

  logic [NUM_DIG-1:0]   mask_q, mask_d;
  logic [4*NUM_DIG-1:0] valores_q, valores_d;
  logic [NUM_DIG-1:0]   digValido_q, digValido_d;
  logic                 trama_q, trama_d;
  logic                 error_q, error_d;

  logic [NUM_DIG-1:0]   digSel;
  logic                 strobeValido;
  logic                 muestraIgual;
  logic [NUM_DIG-1:0]   maskNuevo;

  logic                 decLegal, decBlanco;
  logic [3:0]           decValor;

  // Two-flop synchronizer plus one extra stage holding the previous
  // synchronized sample for the stability compare.
  always_ff @(posedge clk) begin
    if (reset) begin
      anMeta_q  <= '0;
      anSync_q  <= '0;
      anPrev_q  <= '0;
      segMeta_q <= '0;
      segSync_q <= '0;
      segPrev_q <= '0;
    end else begin
      anMeta_q  <= anodos_in;
      anSync_q  <= anMeta_q;
      anPrev_q  <= anSync_q;
      segMeta_q <= segEntrada;
      segSync_q <= segMeta_q;
      segPrev_q <= segSync_q;
    end
  end

  // Active-high copy of the strobe doubles as the one-hot digit select.
  assign digSel       = ~anSync_q;
  assign strobeValido = es_uno_bajo(32'(digSel));
  assign muestraIgual = (anSync_q == anPrev_q) && (segSync_q == segPrev_q);

  decodificador_7seg_bcd uDecodificador (
    .codigo_i (segSync_q[SEG_W-1 -: 7]),
    .legal_o  (decLegal),
    .blanco_o (decBlanco),
    .valor_o  (decValor)
  );

  // FSM and stability counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ESPERA;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state. cnt counts identical samples already seen, so the commit
  // fires on the sample after cnt has reached ESTABLE; that sample also
  // matches its predecessor, so the code decoded now is the stable one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ESPERA: begin
        if (strobeValido) begin
          state_d = ESTABILIZANDO;
          cnt_d   = CNT_UNO;
        end
      end
      ESTABILIZANDO: begin
        if (!strobeValido) begin
          state_d = ESPERA;
        end else if (!muestraIgual) begin
          cnt_d = CNT_UNO;
        end else if (cnt_q >= CNT_MAX) begin
          commit  = 1'b1;
          state_d = CAPTURADO;
        end else begin
          cnt_d = cnt_q + CNT_UNO;
        end
      end
      CAPTURADO: begin
        if (!strobeValido) begin
          state_d = ESPERA;
        end else if (!muestraIgual) begin
          state_d = ESTABILIZANDO;
          cnt_d   = CNT_UNO;
        end
      end
      default: state_d = ESPERA;
    endcase
  end

  // Commit path: update the selected digit, accumulate the frame mask and
  // raise the pulses. An illegal code still counts toward the frame.
  always_comb begin
    valores_d   = valores_q;
    digValido_d = digValido_q;
    mask_d      = mask_q;
    maskNuevo   = mask_q | digSel;
    trama_d     = 1'b0;
    error_d     = 1'b0;
    if (commit) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (digSel[i]) begin
          if (decLegal) begin
            valores_d[4*i +: 4] = decValor;
            digValido_d[i]      = 1'b1;
          end else if (decBlanco) begin
            valores_d[4*i +: 4] = VALOR_BLANCO;
            digValido_d[i]      = 1'b0;
          end else begin
            digValido_d[i]      = 1'b0;
            error_d             = 1'b1;
          end
        end
      end
      if (&maskNuevo) begin
        trama_d = 1'b1;
        mask_d  = '0;
      end else begin
        mask_d  = maskNuevo;
      end
    end
  end

  // Output and mask registers; reset wins over a same-edge commit.
  always_ff @(posedge clk) begin
    if (reset) begin
      valores_q   <= {NUM_DIG{VALOR_BLANCO}};
      digValido_q <= '0;
      mask_q      <= '0;
      trama_q     <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      valores_q   <= valores_d;
      digValido_q <= digValido_d;
      mask_q      <= mask_d;
      trama_q     <= trama_d;
      error_q     <= error_d;
    end
  end

  assign valores_out  = valores_q;
  assign dig_valido   = digValido_q;
  assign trama_valida = trama_q;
  assign error_codigo = error_q;

`ifdef CAPTURA_DP_EN
  logic [NUM_DIG-1:0] dp_q, dp_d;

  // Decimal point is active-low on the bus, stored active-high.
  always_comb begin
    dp_d = dp_q;
    if (commit) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        if (digSel[i]) begin
          dp_d[i] = ~segSync_q[0];
        end
      end
    end
  end

  // Decimal point register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dp_q <= '0;
    end else begin
      dp_q <= dp_d;
    end
  end

  assign dp_out = dp_q;
`endif

endmodule

// File: tb/tb_captura_7seg_bcd.sv
// tb_captura_7seg_bcd
// Directed bench for captura_7seg_bcd with hand-computed expected values.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_captura_7seg_bcd;

  localparam logic [7:0] C0     = 8'b00000011;
  localparam logic [7:0] C1     = 8'b10011111;
  localparam logic [7:0] C2     = 8'b00100101;
  localparam logic [7:0] C3     = 8'b00001101;
  localparam logic [7:0] C4     = 8'b10011001;
  localparam logic [7:0] C5     = 8'b01001001;
  localparam logic [7:0] C6     = 8'b01000001;
  localparam logic [7:0] C7     = 8'b00011111;
  localparam logic [7:0] C8     = 8'b00000001;
  localparam logic [7:0] C9     = 8'b00001001;
  localparam logic [7:0] ILEGAL = 8'b01111111;
  localparam logic [7:0] BLANCO = 8'b11111111;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  anodos_in;
  logic [7:0]  seg_in;
  logic [15:0] valores_out;
  logic [3:0]  dig_valido;
  logic        trama_valida;
  logic        error_codigo;
`ifdef CAPTURA_DP_EN
  logic [3:0]  dpOut;
`endif

  int checks = 0;
  int errors = 0;
  int tramaCount = 0;
  int errorCount = 0;
  int tramaWide = 0;
  int errorWide = 0;
  logic tramaPrev = 1'b0;
  logic errorPrev = 1'b0;
  int baseT, baseE;

  always #5 clk = ~clk;

  captura_7seg_bcd #(.NUM_DIG(4), .ESTABLE(3)) dut (
    .clk          (clk),
    .reset        (reset),
    .anodos_in    (anodos_in),
    .seg_in       (seg_in),
    .valores_out  (valores_out),
    .dig_valido   (dig_valido),
    .trama_valida (trama_valida),
    .error_codigo (error_codigo)
`ifdef CAPTURA_DP_EN
    ,
    .dp_out       (dpOut)
`endif
  );

  // Pulse counters and width monitors.
  always @(negedge clk) begin
    if (trama_valida) tramaCount++;
    if (error_codigo) errorCount++;
    if (trama_valida && tramaPrev) tramaWide++;
    if (error_codigo && errorPrev) errorWide++;
    tramaPrev = trama_valida;
    errorPrev = error_codigo;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observado,
                             input logic [31:0] esperado);
    checks++;
    if (observado !== esperado) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, observado, esperado);
    end
  endtask

  // Drive the bus and hold it for a number of falling edges.
  task automatic applyStimulus(input logic [3:0] an, input logic [7:0] seg,
                               input int ciclos);
    anodos_in = an;
    seg_in    = seg;
    repeat (ciclos) @(negedge clk);
  endtask

  task automatic scanDigito(input int i, input logic [7:0] seg);
    logic [3:0] an;
    an = ~(4'b0001 << i);
    applyStimulus(an, seg, 8);
  endtask

  initial begin
    reset     = 1'b1;
    anodos_in = 4'hF;
    seg_in    = 8'hFF;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    $display("[TB] reset state");
    checkOutput("rst_valores", 32'(valores_out), 32'hFFFF);
    checkOutput("rst_dig_valido", 32'(dig_valido), 32'h0);
    checkOutput("rst_trama", 32'(trama_valida), 32'h0);
    checkOutput("rst_error", 32'(error_codigo), 32'h0);

    baseT = tramaCount;
    baseE = errorCount;
    applyStimulus(4'hF, 8'hFF, 20);
    checkOutput("idle_valores", 32'(valores_out), 32'hFFFF);
    checkOutput("idle_dig_valido", 32'(dig_valido), 32'h0);
    checkOutput("idle_trama_cnt", 32'(tramaCount - baseT), 32'd0);
    checkOutput("idle_error_cnt", 32'(errorCount - baseE), 32'd0);

    $display("[TB] scan 3,1,4,1");
    baseT = tramaCount;
    scanDigito(0, C3);
    scanDigito(1, C1);
    scanDigito(2, C4);
    checkOutput("scan_no_trama_early", 32'(tramaCount - baseT), 32'd0);
    applyStimulus(4'b0111, C1, 5);
    checkOutput("scan_trama_at_4", 32'(trama_valida), 32'h0);
    applyStimulus(4'b0111, C1, 1);
    checkOutput("scan_trama_at_5", 32'(trama_valida), 32'h1);
    checkOutput("scan_valores", 32'(valores_out), 32'h1413);
    checkOutput("scan_dig_valido", 32'(dig_valido), 32'hF);
    applyStimulus(4'b0111, C1, 2);
    applyStimulus(4'hF, 8'hFF, 4);
    checkOutput("scan_trama_cnt", 32'(tramaCount - baseT), 32'd1);

    $display("[TB] illegal code on digit 2");
    baseE = errorCount;
    applyStimulus(4'b1011, ILEGAL, 8);
    applyStimulus(4'hF, 8'hFF, 4);
    checkOutput("ilegal_error_cnt", 32'(errorCount - baseE), 32'd1);
    checkOutput("ilegal_dig_valido", 32'(dig_valido), 32'hB);
    checkOutput("ilegal_valores", 32'(valores_out), 32'h1413);

    $display("[TB] short glitch");
    applyStimulus(4'b1110, C0, 2);
    applyStimulus(4'hF, 8'hFF, 10);
    checkOutput("glitch_valores", 32'(valores_out), 32'h1413);
    checkOutput("glitch_dig_valido", 32'(dig_valido), 32'hB);

    $display("[TB] two anodes low");
    applyStimulus(4'b1100, C8, 10);
    applyStimulus(4'hF, 8'hFF, 4);
    checkOutput("doble_valores", 32'(valores_out), 32'h1413);
    checkOutput("doble_dig_valido", 32'(dig_valido), 32'hB);
    checkOutput("doble_error_cnt", 32'(errorCount - baseE), 32'd1);

    $display("[TB] frame completes with masked illegal digit");
    baseT = tramaCount;
    scanDigito(0, C7);
    scanDigito(1, C2);
    applyStimulus(4'hF, 8'hFF, 2);
    checkOutput("mask_no_trama", 32'(tramaCount - baseT), 32'd0);
    scanDigito(3, C5);
    applyStimulus(4'hF, 8'hFF, 4);
    checkOutput("mask_trama_cnt", 32'(tramaCount - baseT), 32'd1);
    checkOutput("mask_valores", 32'(valores_out), 32'h5427);
    checkOutput("mask_dig_valido", 32'(dig_valido), 32'hB);

    $display("[TB] reset mid-frame");
    scanDigito(0, C9);
    scanDigito(1, C8);
    scanDigito(2, C6);
    reset     = 1'b1;
    anodos_in = 4'hF;
    seg_in    = 8'hFF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    checkOutput("midrst_valores", 32'(valores_out), 32'hFFFF);
    checkOutput("midrst_dig_valido", 32'(dig_valido), 32'h0);
    baseT = tramaCount;
    scanDigito(0, C2);
    scanDigito(1, C0);
    scanDigito(2, C2);
    applyStimulus(4'hF, 8'hFF, 2);
    checkOutput("midrst_no_trama", 32'(tramaCount - baseT), 32'd0);
    scanDigito(3, C4);
    applyStimulus(4'hF, 8'hFF, 4);
    checkOutput("midrst_trama_cnt", 32'(tramaCount - baseT), 32'd1);
    checkOutput("midrst_valores2", 32'(valores_out), 32'h4202);
    checkOutput("midrst_dig_valido2", 32'(dig_valido), 32'hF);

    $display("[TB] blank digit and illegal last digit");
    baseT = tramaCount;
    baseE = errorCount;
    scanDigito(0, C1);
    scanDigito(1, BLANCO);
    scanDigito(2, C1);
    applyStimulus(4'b0111, ILEGAL, 6);
    checkOutput("both_trama", 32'(trama_valida), 32'h1);
    checkOutput("both_error", 32'(error_codigo), 32'h1);
    applyStimulus(4'b0111, ILEGAL, 2);
    applyStimulus(4'hF, 8'hFF, 4);
    checkOutput("both_valores", 32'(valores_out), 32'h41F1);
    checkOutput("both_dig_valido", 32'(dig_valido), 32'h5);
    checkOutput("both_error_cnt", 32'(errorCount - baseE), 32'd1);
    checkOutput("both_trama_cnt", 32'(tramaCount - baseT), 32'd1);

    checkOutput("trama_width", 32'(tramaWide), 32'd0);
    checkOutput("error_width", 32'(errorWide), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
